// File: rtl/mem_credit_arb_if.sv
// Bus bundle for mem_credit_arb: the requester-facing request/response lanes
// and the shared memory-facing request/response port.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
// clk edge where both valid and ready are high. A source holds valid and its
// payload steady until the transfer completes. A sink may raise or drop ready
// at any time.
interface mem_credit_arb_if #(
  parameter int NUM_REQS   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_SIZE  = 64,
  parameter int TAG_WIDTH  = 8
);
  localparam int SEL_W  = $clog2(NUM_REQS);
  localparam int DW     = 8 * DATA_SIZE;
  localparam int MTAG_W = TAG_WIDTH + SEL_W;

  // requester side
  logic [NUM_REQS-1:0]                 req_valid;
  logic [NUM_REQS-1:0]                 req_rw;
  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQS-1:0][DATA_SIZE-1:0]  req_byteen;
  logic [NUM_REQS-1:0][DW-1:0]         req_data;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]  req_tag;
  logic [NUM_REQS-1:0]                 req_ready;
  logic [NUM_REQS-1:0]                 rsp_valid;
  logic [DW-1:0]                       rsp_data;
  logic [TAG_WIDTH-1:0]                rsp_tag;
  logic [NUM_REQS-1:0]                 rsp_ready;

  // memory side
  logic                  mem_req_valid;
  logic                  mem_req_rw;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_SIZE-1:0]  mem_req_byteen;
  logic [DW-1:0]         mem_req_data;
  logic [MTAG_W-1:0]     mem_req_tag;
  logic                  mem_req_ready;
  logic                  mem_rsp_valid;
  logic [DW-1:0]         mem_rsp_data;
  logic [MTAG_W-1:0]     mem_rsp_tag;
  logic                  mem_rsp_ready;

  // arbiter view
  modport master (
    input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output req_ready, rsp_valid, rsp_data, rsp_tag,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data,
    output mem_req_tag, mem_rsp_ready
  );

  // requester/memory environment view
  modport slave (
    output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  req_ready, rsp_valid, rsp_data, rsp_tag,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data,
    input  mem_req_tag, mem_rsp_ready
  );
endinterface

// File: rtl/mem_credit_arb.sv
// Round-robin, read-credit-limited arbiter sharing one memory port among
// NUM_REQS requesters. The requester index rides in the tag LSBs and steers
// responses back. A flush/drain handshake quiesces the port.
module mem_credit_arb #(
  parameter int NUM_REQS    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_SIZE   = 64,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 4,
  localparam int SEL_W      = $clog2(NUM_REQS),
  localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  mem_credit_arb_if.master               bus,
  input  logic                           flush_req,
  output logic                           flush_done,
  output logic [1:0]                     state_dbg,
  output logic [NUM_REQS-1:0][CNT_W-1:0] pending_dbg,
  output logic [SEL_W-1:0]               rr_ptr_dbg
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;

  state_t                         state;
  logic [NUM_REQS-1:0][CNT_W-1:0] pending;
  logic [SEL_W-1:0]               rr_ptr;
  logic [SEL_W-1:0]               grant_idx;
  logic [SEL_W-1:0]               rsp_sel;
  logic [NUM_REQS-1:0]            eligible;
  logic [NUM_REQS-1:0]            grant;
  logic [NUM_REQS-1:0]            inc_vec;
  logic [NUM_REQS-1:0]            dec_vec;
  logic [NUM_REQS-1:0]            rsp_hit;
  int unsigned                    scan_idx;
  logic any_grant, can_load, fire, read_fire, grant_open;
  logic sel_ok, rsp_take, all_idle;

  // Grants stop in the very cycle flush_req rises, not one cycle later.
  assign grant_open = (state == RUN) && !flush_req;

  // A requester may compete if it is valid and, for reads, still holds a credit.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQS; i++)
      eligible[i] = bus.req_valid[i] && grant_open &&
                    (bus.req_rw[i] || (pending[i] < CNT_W'(MAX_PENDING)));
  end

  // Pick the first eligible index at or after rr_ptr, wrapping.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_REQS;
      if (!any_grant && eligible[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx[SEL_W-1:0];
        any_grant       = 1'b1;
      end
    end
  end

  assign can_load      = !bus.mem_req_valid || bus.mem_req_ready;
  assign fire          = any_grant && can_load;
  assign read_fire     = fire && !bus.req_rw[grant_idx];
  assign bus.req_ready = grant & {NUM_REQS{can_load}};
  assign inc_vec       = read_fire ? grant : '0;

  // Response steering: index bits select the requester, upper bits are its tag.
  assign rsp_sel           = bus.mem_rsp_tag[SEL_W-1:0];
  assign sel_ok            = {1'b0, rsp_sel} < (SEL_W + 1)'(NUM_REQS);
  assign bus.rsp_tag       = bus.mem_rsp_tag[TAG_WIDTH+SEL_W-1:SEL_W];
  assign bus.rsp_data      = bus.mem_rsp_data;
  assign bus.mem_rsp_ready = sel_ok ? bus.rsp_ready[rsp_sel] : 1'b1;
  assign rsp_take          = bus.mem_rsp_valid && sel_ok && bus.rsp_ready[rsp_sel];

  // One-hot response valid; nothing is raised for an out-of-range index.
  always_comb begin
    rsp_hit = '0;
    if (bus.mem_rsp_valid && sel_ok) rsp_hit[rsp_sel] = 1'b1;
  end

  assign bus.rsp_valid = rsp_hit;
  assign dec_vec       = rsp_take ? rsp_hit : '0;
  assign all_idle      = !bus.mem_req_valid && (pending == '0);

  // Output register valid: load on fire, clear once memory takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  bus.mem_req_valid <= 1'b0;
    else if (fire)              bus.mem_req_valid <= 1'b1;
    else if (bus.mem_req_ready) bus.mem_req_valid <= 1'b0;
  end

  // Output register payload; only a fire changes it, so it is stable while stalled.
  always_ff @(posedge clk) begin
    if (fire) begin
      bus.mem_req_rw     <= bus.req_rw[grant_idx];
      bus.mem_req_addr   <= bus.req_addr[grant_idx];
      bus.mem_req_byteen <= bus.req_byteen[grant_idx];
      bus.mem_req_data   <= bus.req_data[grant_idx];
      bus.mem_req_tag    <= {bus.req_tag[grant_idx], grant_idx};
    end
  end

  // Round-robin pointer moves past the winner only when the request is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     rr_ptr <= '0;
    else if (fire) rr_ptr <= (grant_idx == SEL_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Read credits: count up on a read fire, down on a consumed response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (inc_vec[i] && !dec_vec[i])                          pending[i] <= pending[i] + 1'b1;
        else if (dec_vec[i] && !inc_vec[i] && pending[i] != '0) pending[i] <= pending[i] - 1'b1;
      end
    end
  end

  // Drain FSM with registered flush_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      case (state)
        RUN:   if (flush_req) state <= DRAIN;
        DRAIN: begin
          if (!flush_req) begin
            state <= RUN;
          end else if (all_idle) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end
        end
        DONE:  begin
          if (!flush_req) begin
            state      <= RUN;
            flush_done <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

  // Flag responses for nonexistent requesters and credit underflow.
  always @(posedge clk) begin
    if (!reset) begin
      a_rsp_sel_range: assert (!(bus.mem_rsp_valid && !sel_ok));
      a_credit_underflow: assert (!(rsp_take && pending[rsp_sel] == '0));
    end
  end

  assign state_dbg   = state;
  assign pending_dbg = pending;
  assign rr_ptr_dbg  = rr_ptr;

endmodule

// File: tb/tb_mem_credit_arb.sv
// Bench for mem_credit_arb: directed scenarios plus a randomized run checked
// against a queue-based reference model of arbitration, credits and routing.
module tb_mem_credit_arb;
  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DS  = 64;
  localparam int DW  = 8 * DS;
  localparam int TW  = 8;
  localparam int MP  = 4;
  localparam int SW  = 2;
  localparam int CW  = 3;
  localparam int MTW = TW + SW;

  logic                     clk;
  logic                     reset;
  logic                     flush_req;
  logic                     flush_done;
  logic [1:0]               state_dbg;
  logic [N-1:0][CW-1:0]     pending_dbg;
  logic [SW-1:0]            rr_ptr_dbg;
  int checks = 0;
  int errors = 0;

  mem_credit_arb_if #(.NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(TW)) bus ();

  mem_credit_arb #(
    .NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(TW), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .flush_req(flush_req), .flush_done(flush_done),
    .state_dbg(state_dbg), .pending_dbg(pending_dbg), .rr_ptr_dbg(rr_ptr_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.req_valid     = '0;
    bus.req_rw        = '0;
    bus.req_addr      = '0;
    bus.req_byteen    = '0;
    bus.req_data      = '0;
    bus.req_tag       = '0;
    bus.rsp_ready     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.mem_rsp_tag   = '0;
    flush_req         = 1'b0;
  endtask

  // Leaves the bench one time unit after a rising edge, reset released.
  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b expected 0", bus.mem_req_valid); end
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done: got %b expected 0", flush_done); end
    checks++; if (pending_dbg !== '0) begin errors++; $display("FAIL reset_pending: got %h expected 0", pending_dbg); end
    checks++; if (state_dbg !== 2'd0 || rr_ptr_dbg !== 2'd0) begin errors++; $display("FAIL reset_state_rr: got %0d/%0d expected 0/0", state_dbg, rr_ptr_dbg); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    logic [DW-1:0] rdata;
    do_reset();
    bus.req_valid         = 4'b0100;
    bus.req_addr[2]       = 32'h100;
    bus.req_tag[2]        = 8'h5A;
    bus.req_byteen[2]     = '1;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready); end
    step();
    bus.req_valid = '0;
    checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus.mem_req_valid); end
    checks++; if (bus.mem_req_tag !== 10'h16A) begin errors++; $display("FAIL single_tag: got %h expected 16a", bus.mem_req_tag); end
    checks++; if (bus.mem_req_addr !== 32'h100 || bus.mem_req_rw !== 1'b0 || bus.mem_req_byteen !== {DS{1'b1}}) begin errors++; $display("FAIL single_payload: got %h/%b expected 100/0", bus.mem_req_addr, bus.mem_req_rw); end
    checks++; if (pending_dbg[2] !== 3'd1) begin errors++; $display("FAIL single_pending_inc: got %0d expected 1", pending_dbg[2]); end
    bus.mem_req_ready = 1'b1;
    step();
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL single_valid_clear: got %b expected 0", bus.mem_req_valid); end
    rdata             = {16{$urandom}};
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_tag   = 10'h16A;
    bus.mem_rsp_data  = rdata;
    bus.rsp_ready     = 4'b0100;
    #1;
    checks++; if (bus.rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid: got %b expected 0100", bus.rsp_valid); end
    checks++; if (bus.rsp_tag !== 8'h5A) begin errors++; $display("FAIL single_rsp_tag: got %h expected 5a", bus.rsp_tag); end
    checks++; if (bus.mem_rsp_ready !== 1'b1 || bus.rsp_data !== rdata) begin errors++; $display("FAIL single_rsp_ready_data: got %b expected 1", bus.mem_rsp_ready); end
    step();
    bus.mem_rsp_valid = 1'b0;
    checks++; if (pending_dbg[2] !== 3'd0) begin errors++; $display("FAIL single_pending_dec: got %0d expected 0", pending_dbg[2]); end
  endtask

  task automatic test_round_robin();
    logic [MTW-1:0] held_tag;
    logic [AW-1:0]  held_addr;
    do_reset();
    for (int i = 0; i < N; i++) begin
      bus.req_tag[i]  = 8'h10 + 8'(i);
      bus.req_addr[i] = 32'hA000 + 32'(i * 16);
    end
    bus.req_valid     = '1;
    bus.req_rw        = '1;
    bus.mem_req_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++; if (bus.req_ready !== 4'(1 << (c % N))) begin errors++; $display("FAIL rr_grant: cycle %0d got %b expected %b", c, bus.req_ready, 4'(1 << (c % N))); end
      step();
      checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_tag !== {8'h10 + 8'(c % N), 2'(c % N)}) begin errors++; $display("FAIL rr_accept: cycle %0d got %h expected %h", c, bus.mem_req_tag, {8'h10 + 8'(c % N), 2'(c % N)}); end
    end
    held_tag          = {8'h13, 2'd3};
    held_addr         = 32'hA030;
    bus.mem_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rr_stall_ready: got %b expected 0000", bus.req_ready); end
      checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_tag !== held_tag || bus.mem_req_addr !== held_addr) begin errors++; $display("FAIL rr_stall_payload: got %h/%h expected %h/%h", bus.mem_req_tag, bus.mem_req_addr, held_tag, held_addr); end
      checks++; if (rr_ptr_dbg !== 2'd0) begin errors++; $display("FAIL rr_stall_ptr: got %0d expected 0", rr_ptr_dbg); end
      step();
    end
    bus.mem_req_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rr_resume: got %b expected 0001", bus.req_ready); end
    step();
    bus.req_valid = '0;
  endtask

  task automatic test_credit_limit();
    int fires1;
    do_reset();
    fires1            = 0;
    bus.req_valid     = 4'b1010;
    bus.req_rw        = 4'b1000;
    bus.req_tag[1]    = 8'hC1;
    bus.mem_req_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.req_ready[1]) fires1++;
      step();
    end
    #1;
    checks++; if (fires1 !== 4) begin errors++; $display("FAIL credit_accepts: got %0d expected 4", fires1); end
    checks++; if (pending_dbg[1] !== 3'd4) begin errors++; $display("FAIL credit_pending_full: got %0d expected 4", pending_dbg[1]); end
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL credit_others_flow: got %b expected 1000", bus.req_ready); end
    bus.req_valid = 4'b0010;
    bus.req_rw    = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL credit_write_flows: got %b expected 0010", bus.req_ready); end
    step();
    checks++; if (pending_dbg[1] !== 3'd4 || bus.mem_req_rw !== 1'b1 || bus.mem_req_tag[1:0] !== 2'd1) begin errors++; $display("FAIL credit_write_no_credit: got %0d/%b expected 4/1", pending_dbg[1], bus.mem_req_rw); end
    bus.req_rw = 4'b0000;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL credit_read_held: got %b expected 0000", bus.req_ready); end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_tag   = {8'hC1, 2'd1};
    bus.rsp_ready     = 4'b0010;
    step();
    bus.mem_rsp_valid = 1'b0;
    checks++; if (pending_dbg[1] !== 3'd3) begin errors++; $display("FAIL credit_returned: got %0d expected 3", pending_dbg[1]); end
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL credit_fifth_accept: got %b expected 0010", bus.req_ready); end
    step();
    bus.req_valid = '0;
    checks++; if (pending_dbg[1] !== 3'd4) begin errors++; $display("FAIL credit_refill: got %0d expected 4", pending_dbg[1]); end
  endtask

  task automatic test_simul_incdec();
    do_reset();
    bus.req_valid     = 4'b0001;
    bus.mem_req_ready = 1'b1;
    step();
    step();
    checks++; if (pending_dbg[0] !== 3'd2) begin errors++; $display("FAIL incdec_setup: got %0d expected 2", pending_dbg[0]); end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_tag   = {8'h33, 2'd0};
    bus.rsp_ready     = 4'b0001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001 || bus.mem_rsp_ready !== 1'b1) begin errors++; $display("FAIL incdec_both_fire: got %b/%b expected 0001/1", bus.req_ready, bus.mem_rsp_ready); end
    step();
    bus.req_valid     = '0;
    bus.mem_rsp_valid = 1'b0;
    checks++; if (pending_dbg[0] !== 3'd2) begin errors++; $display("FAIL incdec_unchanged: got %0d expected 2", pending_dbg[0]); end
  endtask

  task automatic test_drain();
    do_reset();
    bus.req_valid     = 4'b0001;
    bus.mem_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.req_tag[0] = 8'(k);
      step();
    end
    bus.req_valid = '0;
    step();
    checks++; if (pending_dbg[0] !== 3'd3 || bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL drain_setup: got %0d/%b expected 3/0", pending_dbg[0], bus.mem_req_valid); end
    flush_req     = 1'b1;
    bus.req_valid = 4'b0010;
    bus.req_rw    = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL drain_no_grant_same_cycle: got %b expected 0000", bus.req_ready); end
    step();
    checks++; if (state_dbg !== 2'd1 || flush_done !== 1'b0) begin errors++; $display("FAIL drain_enter: got %0d/%b expected 1/0", state_dbg, flush_done); end
    for (int k = 0; k < 3; k++) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_tag   = {8'(k), 2'd0};
      bus.rsp_ready     = 4'b0001;
      #1;
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL drain_no_grant: got %b expected 0000", bus.req_ready); end
      step();
      checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL drain_early_done: rsp %0d got %b expected 0", k, flush_done); end
    end
    bus.mem_rsp_valid = 1'b0;
    step();
    checks++; if (flush_done !== 1'b1 || state_dbg !== 2'd2) begin errors++; $display("FAIL drain_done: got %b/%0d expected 1/2", flush_done, state_dbg); end
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL drain_done_no_grant: got %b expected 0000", bus.req_ready); end
    flush_req = 1'b0;
    step();
    checks++; if (flush_done !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL drain_exit: got %b/%0d expected 0/0", flush_done, state_dbg); end
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL drain_grants_resume: got %b expected 0010", bus.req_ready); end
    step();
    bus.req_valid = '0;
  endtask

  task automatic test_random();
    int             pend[N];
    int             rr;
    int             g;
    int             pick;
    int             sel;
    bit             mv;
    bit             mrw;
    bit             rsp_go;
    bit             exp_mrr;
    logic [MTW-1:0] mtag;
    logic [AW-1:0]  maddr;
    logic [MTW-1:0] rtag;
    logic [DW-1:0]  rdata;
    logic [N-1:0]   exp_ready;
    logic [N-1:0]   exp_rv;
    logic [N-1:0][CW-1:0] exp_pend;
    logic [MTW-1:0] outst[$];
    do_reset();
    rr = 0; mv = 0; mrw = 0; mtag = '0; maddr = '0; pick = 0; sel = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        bus.req_valid[i] = 1'($urandom_range(0, 1));
        bus.req_rw[i]    = ($urandom_range(0, 3) == 0);
        bus.req_tag[i]   = 8'($urandom);
        bus.req_addr[i]  = $urandom;
      end
      bus.mem_req_ready = ($urandom_range(0, 3) != 0);
      bus.rsp_ready     = 4'($urandom);
      rsp_go            = (outst.size() > 0) && ($urandom_range(0, 1) == 1);
      rtag              = '0;
      rdata             = {16{$urandom}};
      if (rsp_go) begin
        pick = $urandom_range(0, outst.size() - 1);
        rtag = outst[pick];
      end
      bus.mem_rsp_valid = rsp_go;
      bus.mem_rsp_tag   = rtag;
      bus.mem_rsp_data  = rdata;
      // reference: first valid requester with a credit (or a write) from rr
      g = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (rr + k) % N;
        if (g < 0 && bus.req_valid[idx] && (bus.req_rw[idx] || pend[idx] < MP)) g = idx;
      end
      exp_ready = '0;
      if (g >= 0 && (!mv || bus.mem_req_ready)) exp_ready[g] = 1'b1;
      sel     = int'(rtag[SW-1:0]);
      exp_rv  = '0;
      exp_mrr = bus.rsp_ready[sel];
      if (rsp_go) exp_rv[sel] = 1'b1;
      #1;
      checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready: cycle %0d got %b expected %b", cyc, bus.req_ready, exp_ready); end
      checks++; if (bus.rsp_valid !== exp_rv) begin errors++; $display("FAIL rand_rsp_valid: cycle %0d got %b expected %b", cyc, bus.rsp_valid, exp_rv); end
      if (rsp_go) begin
        checks++; if (bus.mem_rsp_ready !== exp_mrr || bus.rsp_tag !== rtag[MTW-1:SW] || bus.rsp_data !== rdata) begin errors++; $display("FAIL rand_rsp_route: cycle %0d got %b/%h expected %b/%h", cyc, bus.mem_rsp_ready, bus.rsp_tag, exp_mrr, rtag[MTW-1:SW]); end
      end
      // reference update for the coming edge
      if (rsp_go && exp_mrr) begin
        pend[sel]--;
        outst.delete(pick);
      end
      if (mv && bus.mem_req_ready && !mrw) outst.push_back(mtag);
      if (exp_ready != '0) begin
        if (!bus.req_rw[g]) pend[g]++;
        mv    = 1'b1;
        mrw   = bus.req_rw[g];
        mtag  = {bus.req_tag[g], 2'(g)};
        maddr = bus.req_addr[g];
        rr    = (g + 1) % N;
      end else if (bus.mem_req_ready) begin
        mv = 1'b0;
      end
      step();
      for (int i = 0; i < N; i++) exp_pend[i] = CW'(pend[i]);
      checks++; if (bus.mem_req_valid !== mv) begin errors++; $display("FAIL rand_mem_valid: cycle %0d got %b expected %b", cyc, bus.mem_req_valid, mv); end
      if (mv) begin
        checks++; if (bus.mem_req_tag !== mtag || bus.mem_req_rw !== mrw || bus.mem_req_addr !== maddr) begin errors++; $display("FAIL rand_mem_payload: cycle %0d got %h/%b/%h expected %h/%b/%h", cyc, bus.mem_req_tag, bus.mem_req_rw, bus.mem_req_addr, mtag, mrw, maddr); end
      end
      checks++; if (pending_dbg !== exp_pend) begin errors++; $display("FAIL rand_pending: cycle %0d got %h expected %h", cyc, pending_dbg, exp_pend); end
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    int seq[6];
    logic [N-1:0][CW-1:0] exp_pend;
    seq = '{0, 1, 1, 3, 3, 3};
    do_reset();
    bus.mem_req_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.req_valid = 4'(1 << seq[k]);
      step();
    end
    bus.req_valid     = '0;
    bus.mem_req_ready = 1'b0;
    exp_pend[0] = 3'd1; exp_pend[1] = 3'd2; exp_pend[2] = 3'd0; exp_pend[3] = 3'd3;
    #1;
    checks++; if (bus.mem_req_valid !== 1'b1 || pending_dbg !== exp_pend) begin errors++; $display("FAIL areset_setup: got %b/%h expected 1/%h", bus.mem_req_valid, pending_dbg, exp_pend); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL areset_valid_drop: got %b expected 0", bus.mem_req_valid); end
    checks++; if (pending_dbg !== '0) begin errors++; $display("FAIL areset_pending: got %h expected 0", pending_dbg); end
    @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (state_dbg !== 2'd0 || flush_done !== 1'b0 || rr_ptr_dbg !== 2'd0) begin errors++; $display("FAIL areset_state: got %0d/%b/%0d expected 0/0/0", state_dbg, flush_done, rr_ptr_dbg); end
    bus.req_valid     = 4'b0100;
    bus.req_rw        = 4'b0100;
    bus.mem_req_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL areset_grant_after: got %b expected 0100", bus.req_ready); end
    step();
    bus.req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_credit_limit();
    test_simul_incdec();
    test_drain();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
